mac_tile_dual: RTL and testbench
================================

Name: mac_tile_dual

Overview:
- Next-generation systolic PE for the 2-D MAC array. Supports weight-stationary (WS) and output-stationary (OS) dataflow, selected at run time.
- Signed arithmetic throughout, with a weight-clear/drain instruction.
- In WS, partial sums flow north→south through the tile. In OS, weights flow north→south, activations flow west→east, and the tile holds a local accumulator that is drained down the column.

Parameters:
- bw, 4, activation/weight width (signed two's complement)
- psum_bw, 16, partial-sum/accumulator width (signed); must be ≥ 2*bw

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0=WS, 1=OS; quasi-static, captured only when tile idle
- in_w  input  bw  activation (or WS weight during load) from west
- out_e  output  bw  registered activation to east
- inst_w  input  3  [0]=kernel load (WS), [1]=execute, [2]=clear (WS) / drain (OS)
- inst_e  output  3  registered instruction to east
- in_n  input  psum_bw  WS: psum from north; OS: weight in [bw-1:0], or drain data when inst_w[2]
- out_s  output  psum_bw  WS: MAC result; OS: weight pass-through (sign-extended) or accumulator during drain

Behaviour:
- Reset (async, active-high) clears every register:
  - a_q, b_q, c_q, acc_q, inst_q, exe_q, mode_q = 0; load_ready_q = 1; state = EMPTY.
  - out_s, out_e, inst_e read 0 during and after reset.
  - Reset mid-operation discards all weights, accumulators and pending products.
- State register: EMPTY, WHELD (WS weight held), OSACC, OSDRAIN.
- mode_q <= mode only when inst_w==0 and exe_q==0; mode changes at other times are ignored until that condition holds.
- EMPTY→OSACC when mode_q=1 and inst_w[1]; EMPTY→WHELD on the WS capture below.
- WS mode (mode_q=0):
  - inst_w[0] or inst_w[1]: a_q <= in_w.
  - inst_w[0] with load_ready_q=1: b_q <= in_w, load_ready_q <= 0, EMPTY→WHELD. inst_e[0] is NOT asserted for this cycle, so the next-east tile captures the next weight.
  - inst_w[0] with load_ready_q=0: inst_e[0] <= 1 (load token forwarded).
  - inst_w[1]: c_q <= in_n, inst_e[1] <= 1.
  - out_s = c_q + sext(a_q*b_q), combinational from registers. Latency: in_w/in_n sampled at edge k, out_s/out_e valid after edge k.
  - inst_w[2] (clear): b_q <= 0, load_ready_q <= 1, WHELD→EMPTY, inst_e[2] <= 1.
  - Simultaneous clear with load: clear wins; the load bit is still forwarded.
  - Execute while EMPTY: b_q=0, so out_s = c_q.
- OS mode (mode_q=1):
  - inst_w[1]: a_q <= in_w, b_q <= in_n[bw-1:0], exe_q <= 1, inst_e[1] <= 1.
  - Any edge with exe_q=1 (no drain): acc_q <= acc_q + sext(a_q*b_q). Accumulation therefore trails execute by one edge.
  - OSACC: out_s = sext(b_q), forwarding the weight south with one-cycle latency.
  - inst_w[2] (drain): OSACC/EMPTY→OSDRAIN. out_s = acc_q; acc_q <= in_n; inst_e[2] <= 1.
  - N drain cycles shift a column of N accumulators out of the bottom tile.
  - Drain with exe_q=1 on the same edge: drain has priority and the pending product is dropped. Controllers must leave a one-cycle gap after the last execute.
  - OSDRAIN→EMPTY on the first edge with inst_w[2]=0.
  - Simultaneous execute and drain: drain wins; a_q still updates and execute is forwarded east.
- Arithmetic:
  - Product is signed bw×bw → 2*bw, sign-extended to psum_bw.
  - Sums wrap modulo 2^psum_bw unless MAC_SAT_EN is defined.
- out_e = a_q in both modes. inst_e = inst_q, always exactly one cycle behind inst_w except the WS inst_e[0] suppression.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: WS out_s and the OS acc_q update saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1]. Overflow never wraps.
- Undefined: plain two's-complement wrap; no saturation logic.

Test Plan:
- WS load/execute: reset; mode=0; inst_w=001, in_w=3 → b_q=3, inst_e[0]=0. Then inst_w=010, in_w=-2, in_n=10 → after one edge out_s=4, out_e=-2, inst_e=010.
- WS load token: two consecutive load cycles with in_w=5 then 6 → b_q stays 5; second cycle inst_e[0]=1, out_e=6.
- WS clear: after load of 3, inst_w=100 → load_ready restored. Execute with in_n=7, in_w=4 → out_s=7.
- OS accumulate+drain: mode=1; execute 3 cycles with (in_w,in_n) = (2,3), (-1,4), (7,-8); idle 1 cycle → acc=-54. Drain with in_n=100 → out_s=-54, then out_s=100.
- OS drain priority: execute (1,1), immediately drain → out_s=0, acc_q<=in_n, product dropped.
- Overflow/reset: psum_bw=8, WS, c=120, a=7, b=7 → out_s=-87 (wrap) or 127 (MAC_SAT_EN). Async reset asserted mid-execute → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mac_tile_dual.sv
// mac_tile_dual: systolic MAC processing element with run-time selectable
// weight-stationary (mode=0) or output-stationary (mode=1) dataflow.
// WS: the tile holds a weight; partial sums enter from the north and leave south.
// OS: weights pass north->south, activations west->east, and a local
// accumulator is shifted down the column during drain.
// Optional macro MAC_SAT_EN: saturate WS results and OS accumulation instead of wrapping.
module mac_tile_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic signed [bw-1:0]      in_w,
  output logic signed [bw-1:0]      out_e,
  input  logic [2:0]                inst_w,
  output logic [2:0]                inst_e,
  input  logic signed [psum_bw-1:0] in_n,
  output logic signed [psum_bw-1:0] out_s
);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] WHELD   = 2'd1;
  localparam logic [1:0] OSACC   = 2'd2;
  localparam logic [1:0] OSDRAIN = 2'd3;

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic signed [psum_bw-1:0] prod_ext(input logic signed [bw-1:0] x,
                                                         input logic signed [bw-1:0] y);
    logic signed [2*bw-1:0] p;
    p = (2*bw)'(x) * (2*bw)'(y);
    return (psum_bw)'(p);
  endfunction

  // Accumulator-width addition: clamps on overflow when saturation is enabled.
  function automatic logic signed [psum_bw-1:0] add_fix(input logic signed [psum_bw-1:0] x,
                                                        input logic signed [psum_bw-1:0] y);
`ifdef MAC_SAT_EN
    logic signed [psum_bw:0] s;
    s = (psum_bw+1)'(x) + (psum_bw+1)'(y);
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s[psum_bw-1:0];
`else
    return x + y;
`endif
  endfunction

  logic signed [bw-1:0]      a_q, a_d, b_q, b_d;
  logic signed [psum_bw-1:0] c_q, c_d, acc_q, acc_d;
  logic [2:0]                inst_q, inst_d;
  logic                      exe_q, exe_d, mode_q, mode_d, load_ready_q, load_ready_d;
  logic [1:0]                state_q, state_d;

  assign out_e  = a_q;
  assign inst_e = inst_q;

  // Next-state logic for both dataflows; mode only changes while the tile is idle.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    acc_d        = acc_q;
    inst_d       = inst_w;
    exe_d        = 1'b0;
    mode_d       = mode_q;
    load_ready_d = load_ready_q;
    state_d      = state_q;
    if (inst_w == 3'b000 && !exe_q)
      mode_d = mode;
    if (!mode_q) begin
      if (inst_w[0] || inst_w[1])
        a_d = in_w;
      if (inst_w[1])
        c_d = in_n;
      if (inst_w[2]) begin
        // Clear beats a simultaneous load; the load token still travels east.
        b_d          = '0;
        load_ready_d = 1'b1;
        state_d      = EMPTY;
      end else if (inst_w[0] && load_ready_q) begin
        // This tile keeps the weight, so the load token is not passed east.
        b_d          = in_w;
        load_ready_d = 1'b0;
        state_d      = WHELD;
        inst_d[0]    = 1'b0;
      end
    end else begin
      if (inst_w[1])
        a_d = in_w;
      if (inst_w[2]) begin
        // Drain shifts the column; any pending product is discarded.
        acc_d   = in_n;
        state_d = OSDRAIN;
      end else begin
        if (exe_q)
          acc_d = add_fix(acc_q, prod_ext(a_q, b_q));
        if (inst_w[1]) begin
          b_d   = in_n[bw-1:0];
          exe_d = 1'b1;
        end
        if (state_q == OSDRAIN)
          state_d = EMPTY;
        else if (inst_w[1])
          state_d = OSACC;
      end
    end
  end

  // South output: WS MAC result, OS drained accumulator or forwarded weight.
  always_comb begin
    if (!mode_q)
      out_s = add_fix(c_q, prod_ext(a_q, b_q));
    else if (inst_w[2] || state_q == OSDRAIN)
      out_s = acc_q;
    else
      out_s = (psum_bw)'(b_q);
  end

  // State registers; reset drops weights, accumulators and pending products.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      inst_q       <= '0;
      exe_q        <= 1'b0;
      mode_q       <= 1'b0;
      load_ready_q <= 1'b1;
      state_q      <= EMPTY;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      inst_q       <= inst_d;
      exe_q        <= exe_d;
      mode_q       <= mode_d;
      load_ready_q <= load_ready_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_mac_tile_dual.sv
// Bench for mac_tile_dual: directed vectors, literal checks and a behavioural
// reference model compared on every falling clock edge.
module tb_mac_tile_dual;

  logic               clk = 1'b0;
  logic               reset;
  logic               mode;
  logic signed [3:0]  in_w;
  logic [2:0]         inst_w;
  logic signed [15:0] in_n16;
  logic signed [7:0]  in_n8;
  logic signed [3:0]  out_e16, out_e8;
  logic [2:0]         inst_e16, inst_e8;
  logic signed [15:0] out_s16;
  logic signed [7:0]  out_s8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_tile_dual #(.bw(4), .psum_bw(16)) u16 (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e16),
    .inst_w(inst_w), .inst_e(inst_e16), .in_n(in_n16), .out_s(out_s16)
  );

  mac_tile_dual #(.bw(4), .psum_bw(8)) u8 (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e8),
    .inst_w(inst_w), .inst_e(inst_e8), .in_n(in_n8), .out_s(out_s8)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 16-bit result rule: wrap, or clamp when saturation is built in.
  function automatic int fix16(input int v);
`ifdef MAC_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
`endif
  endfunction

  // Reference model, in terms of held values rather than register encoding.
  int       m_act = 0, m_w = 0, m_psum = 0, m_acc = 0, m_prod = 0;
  bit       m_pend = 0, m_mode = 0, m_ready = 1, m_drain = 0;
  bit [2:0] m_inst = 0;

  always @(posedge clk or posedge reset) begin : model
    int       act, w, psum, acc, prod, wv, nv;
    bit       pend, md, ready, drain;
    bit [2:0] ni;
    if (reset) begin
      m_act <= 0; m_w <= 0; m_psum <= 0; m_acc <= 0; m_prod <= 0;
      m_pend <= 0; m_mode <= 0; m_ready <= 1; m_drain <= 0; m_inst <= 0;
    end else begin
      act = m_act; w = m_w; psum = m_psum; acc = m_acc; prod = m_prod;
      pend = m_pend; md = m_mode; ready = m_ready; drain = m_drain;
      wv = int'(in_w);
      nv = int'(in_n16);
      ni = inst_w;
      if (inst_w == 3'b000 && !m_pend) md = mode;
      if (!m_mode) begin
        if (inst_w[0] || inst_w[1]) act = wv;
        if (inst_w[1]) psum = nv;
        if (inst_w[2]) begin
          w = 0; ready = 1;
        end else if (inst_w[0] && m_ready) begin
          w = wv; ready = 0; ni[0] = 1'b0;
        end
        pend = 0;
      end else begin
        if (inst_w[1]) act = wv;
        if (inst_w[2]) begin
          acc = nv; drain = 1; pend = 0;
        end else begin
          if (m_pend) acc = fix16(m_acc + m_prod);
          drain = 0;
          pend = inst_w[1];
          if (inst_w[1]) begin
            w = int'($signed(in_n16[3:0]));
            prod = wv * w;
          end
        end
      end
      m_act <= act; m_w <= w; m_psum <= psum; m_acc <= acc; m_prod <= prod;
      m_pend <= pend; m_mode <= md; m_ready <= ready; m_drain <= drain; m_inst <= ni;
    end
  end

  function automatic int model_out_s();
    if (!m_mode) return fix16(m_psum + m_act * m_w);
    if (inst_w[2] || m_drain) return m_acc;
    return m_w;
  endfunction

  // Continuous comparison of the 16-bit tile against the model.
  always @(negedge clk) begin
    chk("model out_s", int'(out_s16), model_out_s());
    chk("model out_e", int'(out_e16), m_act);
    chk("model inst_e", int'(inst_e16), int'(m_inst));
  end

  task automatic drive(input logic [2:0] i, input int w, input int n);
    inst_w = i;
    in_w   = w[3:0];
    in_n16 = n[15:0];
    in_n8  = n[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(3'b000, 0, 0);
    tick();
    chk("rst out_s", int'(out_s16), 0);
    chk("rst out_e", int'(out_e16), 0);
    chk("rst inst_e", int'(inst_e16), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    drive(3'b000, 0, 0);
    tick();
    chk("rst out_s8", int'(out_s8), 0);
    do_reset();

    // WS load then execute
    drive(3'b001, 3, 0);  tick();
    chk("ws load inst_e", int'(inst_e16), 0);
    chk("ws load out_s", int'(out_s16), 9);
    drive(3'b010, -2, 10); tick();
    chk("ws exe out_s", int'(out_s16), 4);
    chk("ws exe out_e", int'(out_e16), -2);
    chk("ws exe inst_e", int'(inst_e16), 2);

    // WS load token forwarding
    do_reset();
    drive(3'b001, 5, 0); tick();
    drive(3'b001, 6, 0); tick();
    chk("token inst_e", int'(inst_e16), 1);
    chk("token out_e", int'(out_e16), 6);
    drive(3'b010, 1, 0); tick();
    chk("token weight kept", int'(out_s16), 5);

    // WS clear, reload, clear+load together
    do_reset();
    drive(3'b001, 3, 0); tick();
    drive(3'b100, 0, 0); tick();
    chk("clear inst_e", int'(inst_e16), 4);
    drive(3'b010, 4, 7); tick();
    chk("clear exe out_s", int'(out_s16), 7);
    drive(3'b001, 2, 0); tick();
    chk("reload captured", int'(inst_e16), 0);
    drive(3'b010, 1, 0); tick();
    chk("reload out_s", int'(out_s16), 2);
    drive(3'b101, 3, 0); tick();
    chk("clr+load inst_e", int'(inst_e16), 5);
    chk("clr+load out_s", int'(out_s16), 0);
    drive(3'b001, 6, 0); tick();
    chk("after clr+load capture", int'(inst_e16), 0);

    // OS accumulate and drain
    mode = 1'b1;
    do_reset();
    drive(3'b000, 0, 0);   tick();
    drive(3'b010, 2, 3);   tick();
    chk("os fwd w", int'(out_s16), 3);
    drive(3'b010, -1, 4);  tick();
    drive(3'b010, 7, -8);  tick();
    chk("os fwd w2", int'(out_s16), -8);
    chk("os out_e", int'(out_e16), 7);
    drive(3'b000, 0, 0);   tick();
    chk("os idle inst_e", int'(inst_e16), 0);
    drive(3'b100, 0, 100); #1;
    chk("os drain acc", int'(out_s16), -54);
    tick();
    drive(3'b000, 0, 0);   #1;
    chk("os drain shifted", int'(out_s16), 100);
    chk("os drain inst_e", int'(inst_e16), 4);
    tick();
    chk("os back to w", int'(out_s16), -8);

    // OS drain priority over pending product
    do_reset();
    drive(3'b000, 0, 0);  tick();
    drive(3'b010, 1, 1);  tick();
    drive(3'b100, 0, 42); #1;
    chk("prio drain out", int'(out_s16), 0);
    tick();
    drive(3'b000, 0, 0);  #1;
    chk("prio acc=in_n", int'(out_s16), 42);
    tick();
    drive(3'b100, 0, 0);  #1;
    chk("prio product dropped", int'(out_s16), 42);
    tick();
    drive(3'b000, 0, 0);  tick();
    drive(3'b110, 5, 9);  tick();
    drive(3'b000, 0, 0);  #1;
    chk("exe+drain out_e", int'(out_e16), 5);
    chk("exe+drain inst_e", int'(inst_e16), 6);
    chk("exe+drain acc", int'(out_s16), 9);
    tick();

    // Narrow accumulator overflow, then async reset mid-execute
    mode = 1'b0;
    do_reset();
    drive(3'b000, 0, 0);   tick();
    drive(3'b001, 7, 0);   tick();
    drive(3'b010, 7, 120); tick();
`ifdef MAC_SAT_EN
    chk("ovf8 out_s", int'(out_s8), 127);
`else
    chk("ovf8 out_s", int'(out_s8), -87);
`endif
    chk("ovf16 out_s", int'(out_s16), 169);
    drive(3'b010, 3, 50);
    #2 reset = 1'b1;
    #1;
    chk("async rst out_s", int'(out_s16), 0);
    chk("async rst out_s8", int'(out_s8), 0);
    chk("async rst out_e", int'(out_e16), 0);
    chk("async rst inst_e", int'(inst_e16), 0);
    tick();
    reset = 1'b0;
    drive(3'b000, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
